// File: rtl/jedro_1_mem_arbiter_if.sv
// Bus bundle between jedro_1 fetch/load-store ports, the memory arbiter and the shared RAM.
// The slave modport is the arbiter's view; master is the core+RAM environment view.
interface jedro_1_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  i_req_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic                  i_gnt_o;
    logic                  i_rvalid_o;
    logic [DATA_WIDTH-1:0] i_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [BE_WIDTH-1:0]   d_be_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;

    logic                  m_en_o;
    logic [BE_WIDTH-1:0]   m_we_o;
    logic [ADDR_WIDTH-1:0] m_addr_o;
    logic [DATA_WIDTH-1:0] m_wdata_o;
    logic [DATA_WIDTH-1:0] m_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output m_en_o, m_we_o, m_addr_o, m_wdata_o,
        input  m_rdata_i
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  m_en_o, m_we_o, m_addr_o, m_wdata_o,
        output m_rdata_i
    );
endinterface

// File: rtl/jedro_1_mem_arbiter.sv
// Two-master (fetch / load-store) arbiter for one single-port, 1-cycle-latency RAM.
// Define JEDRO_1_MEM_ARB_RR_EN for round-robin; otherwise data-first with a MAX_WAIT starvation guard.
module jedro_1_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    jedro_1_mem_arbiter_if.slave bus
);
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    logic                      i_gnt;
    logic                      d_gnt;
    logic                      tag_valid;
    owner_e                    tag_owner;
    logic [ADDR_WIDTH-1:0]     addr_sel;
    logic [DATA_WIDTH/8-1:0]   we_sel;

`ifdef JEDRO_1_MEM_ARB_RR_EN
    owner_e rr_last;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_last <= OWN_I;
        else if (i_gnt)
            rr_last <= OWN_I;
        else if (d_gnt)
            rr_last <= OWN_D;
    end

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst_i) begin
            if (bus.i_req_i && bus.d_req_i) begin
                if (rr_last == OWN_D) i_gnt = 1'b1;
                else                  d_gnt = 1'b1;
            end else begin
                i_gnt = bus.i_req_i;
                d_gnt = bus.d_req_i;
            end
        end
    end
`else
    localparam int             CNT_WIDTH = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WAIT);

    logic [CNT_WIDTH-1:0] starve_cnt;

    // Counts consecutive denied fetch cycles; saturates so fetch keeps priority until served.
    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.i_req_i || i_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != MAX_CNT)
            starve_cnt <= starve_cnt + 1'b1;
    end

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst_i) begin
            if (bus.i_req_i && bus.d_req_i) begin
                if (starve_cnt == MAX_CNT) i_gnt = 1'b1;
                else                       d_gnt = 1'b1;
            end else begin
                i_gnt = bus.i_req_i;
                d_gnt = bus.d_req_i;
            end
        end
    end
`endif

    always_comb begin
        addr_sel = d_gnt ? bus.d_addr_i : bus.i_addr_i;
        we_sel   = (d_gnt && bus.d_we_i) ? bus.d_be_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_valid <= 1'b0;
            tag_owner <= OWN_I;
        end else begin
            tag_valid <= i_gnt || d_gnt;
            tag_owner <= d_gnt ? OWN_D : OWN_I;
        end
    end

    assign bus.i_gnt_o    = i_gnt;
    assign bus.d_gnt_o    = d_gnt;
    assign bus.m_en_o     = i_gnt || d_gnt;
    assign bus.m_we_o     = we_sel;
    assign bus.m_addr_o   = addr_sel;
    assign bus.m_wdata_o  = bus.d_wdata_i;

    // Gating with rst_i drops a response whose grant preceded the reset cycle.
    assign bus.i_rvalid_o = !rst_i && tag_valid && (tag_owner == OWN_I);
    assign bus.d_rvalid_o = !rst_i && tag_valid && (tag_owner == OWN_D);
    assign bus.i_rdata_o  = bus.m_rdata_i;
    assign bus.d_rdata_o  = bus.m_rdata_i;
endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Self-checking bench for jedro_1_mem_arbiter: grant vector table, RAM model and response scoreboard.
// Build with JEDRO_1_MEM_ARB_RR_EN to check the round-robin variant.
module tb_jedro_1_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jedro_1_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    jedro_1_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // RAM model: byte-write, registered read (read-before-write)
    logic [DW-1:0] ram     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (bus.m_en_o) begin
            for (int b = 0; b < BW; b++)
                if (bus.m_we_o[b]) ram[bus.m_addr_o[9:2]][8*b +: 8] <= bus.m_wdata_o[8*b +: 8];
            bus.m_rdata_i <= ram[bus.m_addr_o[9:2]];
        end
    end

    typedef struct {
        logic          own_d;
        logic          is_store;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sb[$];

    // Mid-cycle monitor: pop the previous cycle's grant, then record this cycle's grant.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            chk("rvalid_in_reset", {62'd0, bus.i_rvalid_o, bus.d_rvalid_o}, 64'd0);
            sb.delete();
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rvalid_owner", {62'd0, bus.i_rvalid_o, bus.d_rvalid_o},
                    e.own_d ? 64'd1 : 64'd2);
                if (!e.own_d)
                    chk("i_rdata", {32'd0, bus.i_rdata_o}, {32'd0, e.data});
                else if (!e.is_store)
                    chk("d_rdata", {32'd0, bus.d_rdata_o}, {32'd0, e.data});
            end else begin
                chk("rvalid_idle", {62'd0, bus.i_rvalid_o, bus.d_rvalid_o}, 64'd0);
            end
            if (bus.i_gnt_o) begin
                e.own_d = 1'b0; e.is_store = 1'b0; e.data = ref_mem[bus.i_addr_i[9:2]];
                sb.push_back(e);
            end else if (bus.d_gnt_o) begin
                e.own_d = 1'b1; e.is_store = bus.d_we_i; e.data = ref_mem[bus.d_addr_i[9:2]];
                sb.push_back(e);
                if (bus.d_we_i)
                    for (int b = 0; b < BW; b++)
                        if (bus.d_be_i[b])
                            ref_mem[bus.d_addr_i[9:2]][8*b +: 8] = bus.d_wdata_i[8*b +: 8];
            end
        end
    end

    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                         input logic dw, input logic [BW-1:0] be,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd);
        bus.i_req_i   = ir;
        bus.i_addr_i  = ia;
        bus.d_req_i   = dr;
        bus.d_we_i    = dw;
        bus.d_be_i    = be;
        bus.d_addr_i  = da;
        bus.d_wdata_i = wd;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string name, input logic [1:0] exp);
        chk(name, {62'd0, bus.i_gnt_o, bus.d_gnt_o}, {62'd0, exp});
    endtask

    typedef struct {
        logic       ir;
        logic       dr;
        logic [1:0] gnt;   // {i_gnt, d_gnt}
    } vec_t;
    vec_t tbl [16];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
        ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;

        for (int i = 0; i < 16; i++) begin
            tbl[i].ir = 1'b0; tbl[i].dr = 1'b0; tbl[i].gnt = 2'b00;
        end
        for (int i = 3; i < 13; i++) begin
            tbl[i].ir = 1'b1; tbl[i].dr = 1'b1;
`ifdef JEDRO_1_MEM_ARB_RR_EN
            tbl[i].gnt = ((i - 3) % 2 == 0) ? 2'b01 : 2'b10;
`else
            tbl[i].gnt = ((i - 3) % 5 == 4) ? 2'b10 : 2'b01;
`endif
        end
        tbl[13].ir = 1'b1; tbl[13].gnt = 2'b10;
        tbl[14].dr = 1'b1; tbl[14].gnt = 2'b01;

        // Reset with both masters requesting
        drive(1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'hFFFF_FFFF);
        next_cycle();
        #1;
        chk_gnt("gnt_in_reset", 2'b00);
        chk("m_en_in_reset", {63'd0, bus.m_en_o}, 64'd0);
        chk("m_we_in_reset", {60'd0, bus.m_we_o}, 64'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            #1;
            chk_gnt("idle_gnt", 2'b00);
            chk("idle_m_en", {63'd0, bus.m_en_o}, 64'd0);
            chk("idle_m_we", {60'd0, bus.m_we_o}, 64'd0);
            next_cycle();
        end

        // Grant vector table: fetch addr 0x0, load addr 0x4
        for (int v = 0; v < 16; v++) begin
            drive(tbl[v].ir, 32'h0, tbl[v].dr, 1'b0, 4'h0, 32'h4, 32'h0);
            #1;
            chk_gnt($sformatf("tbl_gnt[%0d]", v), tbl[v].gnt);
            chk($sformatf("tbl_m_en[%0d]", v), {63'd0, bus.m_en_o}, {63'd0, |tbl[v].gnt});
            if (tbl[v].gnt != 2'b00)
                chk($sformatf("tbl_m_addr[%0d]", v), {32'd0, bus.m_addr_o},
                    tbl[v].gnt[0] ? 64'h4 : 64'h0);
            next_cycle();
        end

        // Fetch only, back-to-back 0x0, 0x4, 0x8
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, AW'(a * 4), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            #1;
            chk_gnt("fetch_seq_gnt", 2'b10);
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("fetch_last_data", {32'd0, bus.i_rdata_o}, 64'h33);
        next_cycle();

        // Partial store then load of the same word
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk_gnt("store_gnt", 2'b01);
        chk("store_m_we", {60'd0, bus.m_we_o}, 64'h3);
        chk("store_m_addr", {32'd0, bus.m_addr_o}, 64'h10);
        chk("store_m_wdata", {32'd0, bus.m_wdata_o}, 64'hDEAD_BEEF);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'b0011, 32'h10, 32'h0);
        #1;
        chk_gnt("load_gnt", 2'b01);
        chk("load_m_we", {60'd0, bus.m_we_o}, 64'h0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("load_rvalid", {63'd0, bus.d_rvalid_o}, 64'd1);
        chk("load_data", {32'd0, bus.d_rdata_o}, 64'h0000_BEEF);
        next_cycle();

        // Reset the cycle after a fetch grant: response must be dropped
        drive(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk_gnt("pre_reset_gnt", 2'b10);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h0);
        #1;
        chk("reset_drop_i_rvalid", {63'd0, bus.i_rvalid_o}, 64'd0);
        chk_gnt("reset_gnt", 2'b00);
        chk("reset_m_en", {63'd0, bus.m_en_o}, 64'd0);
        chk("reset_m_we", {60'd0, bus.m_we_o}, 64'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        #1;
        chk_gnt("post_reset_contend", 2'b01);
        chk("post_reset_no_rvalid", {62'd0, bus.i_rvalid_o, bus.d_rvalid_o}, 64'd0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/jedro_1_mem_arbiter.md
# jedro_1_mem_arbiter

Two-master arbiter sharing one single-port, one-cycle-read-latency RAM between the jedro_1 instruction-fetch port and the load/store port. It sits between the core and the bytewrite RAM so that instruction and data images live in one unified memory. It grants at most one request per cycle, drives the RAM, and routes the returned read data to the master that issued it. Fixed data-first priority is backed by a starvation guard; round-robin is a compile-time option.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; multiple of 8
- MAX_WAIT, 4, consecutive denied instruction cycles before fetch is forced to win (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- i_req_i  in  1  fetch request
- i_addr_i  in  ADDR_WIDTH  fetch address
- i_gnt_o  out  1  fetch granted this cycle (combinational)
- i_rvalid_o  out  1  fetch read data valid
- i_rdata_o  out  DATA_WIDTH  fetch read data
- d_req_i  in  1  load/store request
- d_we_i  in  1  1 = store
- d_be_i  in  DATA_WIDTH/8  store byte enables
- d_addr_i  in  ADDR_WIDTH  load/store address
- d_wdata_i  in  DATA_WIDTH  store data
- d_gnt_o  out  1  load/store granted this cycle (combinational)
- d_rvalid_o  out  1  load data valid / store acknowledge
- d_rdata_o  out  DATA_WIDTH  load data
- m_en_o  out  1  RAM access enable
- m_we_o  out  DATA_WIDTH/8  RAM byte write enables
- m_addr_o  out  ADDR_WIDTH  RAM address
- m_wdata_o  out  DATA_WIDTH  RAM write data
- m_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after m_en_o

## Operation
- Masters hold req and request fields stable until gnt; a request completes in the gnt cycle.
- Exactly one of i_gnt_o/d_gnt_o is high when any req is high; neither is high otherwise.
- Single requester is always granted.
- Contention in default mode: data wins, unless starve_cnt == MAX_WAIT, in which case fetch wins.
- starve_cnt (width clog2(MAX_WAIT+1)) increments, saturating at MAX_WAIT, each cycle i_req_i is high and i_gnt_o is low. It clears when i_gnt_o is high or i_req_i is low.
- RAM drive on grant:
  - m_en_o = 1.
  - m_addr_o and m_wdata_o take the granted master's fields.
  - m_we_o = d_be_i if data is granted with d_we_i = 1, else 0.
- When idle: m_en_o = 0 and m_we_o = 0; m_addr_o/m_wdata_o are don't-care.
- Owner tag register: records {valid, owner} of each grant.
- Response routing on the next cycle: tag valid asserts i_rvalid_o or d_rvalid_o per owner. Both rdata outputs mirror m_rdata_i. d_rdata_o is undefined for store acknowledges.
- Grants may issue every cycle (fully pipelined); responses return in issue order.

## Timing
- Grant latency: 0 cycles (combinational from req, starve_cnt and rr state).
- Read latency: rvalid exactly 1 cycle after gnt; store ack 1 cycle after gnt.
- Reset values:
  - starve_cnt = 0, owner tag valid = 0, rr_last = fetch.
  - All gnt, rvalid, m_en_o and m_we_o outputs = 0 during and after reset.
- Reset asserted with a response pending: the response is dropped and no rvalid follows reset.
- Simultaneous gnt and a returning response for the same master are legal and independent.
- No combinational path from m_rdata_i to any gnt.

## Configuration
- JEDRO_1_MEM_ARB_RR_EN defined: on contention, grant the master not granted most recently (rr_last updates on every grant). starve_cnt is not implemented and MAX_WAIT is ignored.
- Undefined: fixed data-first priority with the MAX_WAIT starvation guard as above.

## Test plan
- Fetch only, addr 0x0,0x4,0x8 back-to-back with RAM preloaded 0x11,0x22,0x33 → i_gnt_o high 3 cycles; i_rvalid_o high the following 3 cycles with data 0x11,0x22,0x33; d_rvalid_o never high.
- Store 0xDEADBEEF to 0x10 with be 4'b0011, then load 0x10 → m_we_o = 4'b0011 in the store cycle; load returns 0x0000BEEF if memory was 0; d_rvalid_o on both.
- Both requesting continuously, MAX_WAIT = 4, default build → pattern D,D,D,D,I repeating; fetch is never denied more than 4 consecutive cycles.
- Same stimulus with JEDRO_1_MEM_ARB_RR_EN → first contention grants data, then strict alternation I,D,I,D.
- rst_i asserted the cycle after a fetch grant → no i_rvalid_o; all outputs 0; after release, first contended cycle grants data.
- No requests for 10 cycles → m_en_o, all gnt and rvalid stay 0; starve_cnt stays 0.
